// File: rtl/pl_id_ex_stage_pkg.sv
// Shared MIPS pipeline types: ALU codes, ID/EX control bundle, forward selectors.
// Imported by the ID/EX stage and its forwarding unit.
package pl_id_ex_stage_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_control;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/pl_forward_unit.sv
// Combinational operand forwarding: picks EX/MEM, then MEM/WB, else reg value.
// Ports: src addr, two write-back tags, three candidates -> fwd_val, fwd_sel.
import pl_id_ex_stage_pkg::*;

module pl_forward_unit #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  reg_val,
  input  logic [DATA_W-1:0]  exmem_res,
  input  logic [DATA_W-1:0]  memwb_wdata,
  output logic [DATA_W-1:0]  fwd_val,
  output fwd_sel_t           fwd_sel
);

  logic src_nz;
  logic ex_hit;
  logic wb_hit;

  always_comb begin
    src_nz  = (src != '0);
    ex_hit  = exmem_reg_write & (exmem_rd == src) & src_nz;
    // the younger EX/MEM result shadows MEM/WB
    wb_hit  = memwb_reg_write & (memwb_rd == src) & src_nz & ~ex_hit;
    fwd_sel = FWD_REG;
    fwd_val = reg_val;
    unique case (1'b1)
      ex_hit: begin
        fwd_sel = FWD_EXMEM;
        fwd_val = exmem_res;
      end
      wb_hit: begin
        fwd_sel = FWD_MEMWB;
        fwd_val = memwb_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pl_id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use detection.
// Ports: id_* decode inputs, flush/hold, fwd tags in; ALU operands, EX ctrl out.
import pl_id_ex_stage_pkg::*;

module pl_id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_uses_rt,
  input  logic [3:0]         id_alu_control,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_branch,
  input  logic               flush,
  input  logic               hold,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_res,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_wdata,
  output logic [DATA_W-1:0]  alu_op1,
  output logic [DATA_W-1:0]  alu_op2,
  output logic [3:0]         alu_control,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_write_reg,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_branch,
  output logic               load_use_stall
);

  idex_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [RADDR_W-1:0] rs_q, rs_d;
  logic [RADDR_W-1:0] rt_q, rt_d;
  logic [RADDR_W-1:0] rd_q, rd_d;

  logic [DATA_W-1:0]  fwd_rs;
  logic [DATA_W-1:0]  fwd_rt;
  fwd_sel_t           rs_sel;
  fwd_sel_t           rt_sel;
  logic               unused_sel;
  logic               rt_hit;

  always_comb begin
    rt_hit = (rt_q == id_rs) | (id_uses_rt & (rt_q == id_rt));
    load_use_stall = id_valid & ~hold & ctrl_q.valid &
                     ctrl_q.mem_read & (rt_q != '0) & rt_hit;
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (hold) begin
    end else if (flush | load_use_stall) begin
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end else begin
      ctrl_d.valid       = id_valid;
      ctrl_d.reg_write   = id_valid & id_reg_write;
      ctrl_d.mem_read    = id_valid & id_mem_read;
      ctrl_d.mem_write   = id_valid & id_mem_write;
      ctrl_d.mem_to_reg  = id_valid & id_mem_to_reg;
      ctrl_d.branch      = id_valid & id_branch;
      ctrl_d.alu_src     = id_valid & id_alu_src;
      ctrl_d.reg_dst     = id_valid & id_reg_dst;
      ctrl_d.alu_control = id_alu_control;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  pl_forward_unit #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs (
    .src             (rs_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .reg_val         (rs_data_q),
    .exmem_res       (exmem_res),
    .memwb_wdata     (memwb_wdata),
    .fwd_val         (fwd_rs),
    .fwd_sel         (rs_sel)
  );

  pl_forward_unit #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_fwd_rt (
    .src             (rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .reg_val         (rt_data_q),
    .exmem_res       (exmem_res),
    .memwb_wdata     (memwb_wdata),
    .fwd_val         (fwd_rt),
    .fwd_sel         (rt_sel)
  );

  assign unused_sel = ^{rs_sel, rt_sel};

  always_comb begin
    alu_op1       = fwd_rs;
    alu_op2       = ctrl_q.alu_src ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    ex_write_reg  = ctrl_q.reg_dst ? rd_q : rt_q;
    alu_control   = ctrl_q.alu_control;
    ex_valid      = ctrl_q.valid;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
    ex_branch     = ctrl_q.branch;
  end

endmodule

// File: tb/tb_pl_id_ex_stage.sv
// Self-checking bench for pl_id_ex_stage: directed table, corner
// sequences and random traffic against a behavioural slot model.
module tb_pl_id_ex_stage;
  import pl_id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [3:0]  id_alu_control;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read;
  logic        id_mem_write, id_mem_to_reg, id_branch;
  logic        flush, hold;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_res;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wdata;
  logic [31:0] alu_op1, alu_op2, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_write_reg;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_branch, load_use_stall;

  int checks = 0;
  int errors = 0;

  pl_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .flush(flush), .hold(hold),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_res(exmem_res), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // instruction currently sitting in EX, as the model sees it
  typedef struct packed {
    logic        v;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu;
    logic        src, dst, rw, mr, mw, m2r, br;
  } slot_t;
  slot_t m;

  localparam logic [7:0] C_RTYPE = 8'b1011_0000;
  localparam logic [7:0] C_LW    = 8'b0101_1010;
  localparam logic [7:0] C_SW    = 8'b1100_0100;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src,
                                      input logic [31:0] rv);
    if (src == 0) return rv;
    if (exmem_reg_write && exmem_rd == src) return exmem_res;
    if (memwb_reg_write && memwb_rd == src) return memwb_wdata;
    return rv;
  endfunction

  function automatic logic model_stall();
    if (!id_valid || hold || !m.v || !m.mr || m.rt == 0) return 1'b0;
    return (m.rt == id_rs) || (id_uses_rt && m.rt == id_rt);
  endfunction

  function automatic slot_t cap();
    slot_t s;
    s.v   = id_valid;
    s.rsd = id_rs_data; s.rtd = id_rt_data; s.imm = id_imm;
    s.rs  = id_rs; s.rt = id_rt; s.rd = id_rd;
    s.alu = id_alu_control;
    s.src = id_valid && id_alu_src;
    s.dst = id_valid && id_reg_dst;
    s.rw  = id_valid && id_reg_write;
    s.mr  = id_valid && id_mem_read;
    s.mw  = id_valid && id_mem_write;
    s.m2r = id_valid && id_mem_to_reg;
    s.br  = id_valid && id_branch;
    return s;
  endfunction

  task automatic tick();
    logic st;
    st = model_stall();
    if (!rst_n) m = '0;
    else if (!hold) m = (flush || st) ? slot_t'('0) : cap();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    logic [31:0] rt_val;
    #2;
    rt_val = fwd(m.rt, m.rtd);
    chk("stall", load_use_stall, model_stall());
    chk("ex_valid", ex_valid, m.v);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_mem_to_reg", ex_mem_to_reg, m.m2r);
    chk("ex_branch", ex_branch, m.br);
    chk("alu_op1", alu_op1, fwd(m.rs, m.rsd));
    chk("store_data", ex_store_data, rt_val);
    if (m.v) begin
      chk("alu_op2", alu_op2, m.src ? m.imm : rt_val);
      chk("alu_control", alu_control, m.alu);
      chk("write_reg", ex_write_reg, m.dst ? m.rd : m.rt);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_alu_control = 0; id_alu_src = 0; id_reg_dst = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_branch = 0; flush = 0; hold = 0;
  endtask

  task automatic nofwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_res = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
  endtask

  task automatic instr(input logic [4:0] rs, rt, rd,
                       input logic [31:0] rsd, rtd, imm,
                       input logic [3:0] alu, input logic [7:0] c);
    id_valid = 1;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_control = alu;
    {id_uses_rt, id_alu_src, id_reg_dst, id_reg_write,
     id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = c;
  endtask

  typedef struct {
    string       nm;
    logic [4:0]  rs;
    logic [31:0] rsd;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwd;
    logic [31:0] exp;
  } fv_t;
  fv_t tbl[6];

  initial begin
    tbl[0] = '{"fwd_both",   3, 32'h55, 1, 3, 32'h10, 1, 3, 32'h20, 32'h10};
    tbl[1] = '{"fwd_memwb",  3, 32'h55, 0, 3, 32'h10, 1, 3, 32'h20, 32'h20};
    tbl[2] = '{"fwd_rd0",    3, 32'h55, 1, 0, 32'h10, 1, 0, 32'h20, 32'h55};
    tbl[3] = '{"fwd_none",   3, 32'h55, 1, 4, 32'h10, 1, 5, 32'h20, 32'h55};
    tbl[4] = '{"fwd_r0",     0, 32'h0,  1, 0, 32'h10, 1, 0, 32'h20, 32'h0};
    tbl[5] = '{"fwd_exonly", 3, 32'h55, 1, 3, 32'h77, 0, 3, 32'h20, 32'h77};

    rst_n = 0; m = '0;
    idle(); nofwd();
    #3;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_alu_control", alu_control, 0);
    #9 rst_n = 1;
    @(posedge clk); #1;

    // add r3,r1,r2 with r1=5, r2=7
    instr(1, 2, 3, 5, 7, 0, ALU_CTRL_ADD, C_RTYPE);
    check_all(); tick(); idle();
    check_all();
    chk("add_op1", alu_op1, 5);
    chk("add_op2", alu_op2, 7);
    chk("add_ctrl", alu_control, ALU_CTRL_ADD);
    chk("add_wreg", ex_write_reg, 3);

    // asynchronous reset with a valid instruction in EX
    chk("pre_rst_valid", ex_valid, 1);
    rst_n = 0; #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_rw", ex_reg_write, 0);
    chk("mid_rst_op1", alu_op1, 0);
    m = '0; rst_n = 1;
    tick();

    foreach (tbl[i]) begin
      instr(tbl[i].rs, 7, 9, tbl[i].rsd, 1, 0, ALU_CTRL_ADD, C_RTYPE);
      tick(); idle();
      exmem_reg_write = tbl[i].exw; exmem_rd = tbl[i].exrd;
      exmem_res = tbl[i].exres;
      memwb_reg_write = tbl[i].mww; memwb_rd = tbl[i].mwrd;
      memwb_wdata = tbl[i].mwd;
      #2 chk(tbl[i].nm, alu_op1, tbl[i].exp);
      nofwd(); tick();
    end

    // lw r4,0(r1) then add r5,r4,r1
    instr(1, 4, 0, 32'h100, 32'h1111, 0, ALU_CTRL_ADD, C_LW);
    tick();
    instr(4, 1, 5, 32'h1111, 32'h100, 0, ALU_CTRL_ADD, C_RTYPE);
    check_all();
    chk("lu_stall", load_use_stall, 1);
    tick();
    exmem_reg_write = 1; exmem_rd = 4; exmem_res = 32'h100;
    check_all();
    chk("lu_stall_once", load_use_stall, 0);
    chk("lu_bubble", ex_valid, 0);
    tick(); idle(); nofwd();
    memwb_reg_write = 1; memwb_rd = 4; memwb_wdata = 32'hCAFE;
    check_all();
    chk("lu_fwd_op1", alu_op1, 32'hCAFE);
    chk("lu_add_valid", ex_valid, 1);
    nofwd(); tick();

    // sw r6,8(r2), r6 from EX/MEM
    instr(2, 6, 0, 32'h40, 32'h1, 8, ALU_CTRL_ADD, C_SW);
    tick(); idle();
    exmem_reg_write = 1; exmem_rd = 6; exmem_res = 32'hDEAD;
    check_all();
    chk("sw_op2", alu_op2, 8);
    chk("sw_store", ex_store_data, 32'hDEAD);
    nofwd(); tick();

    // flush kills the incoming instruction
    instr(1, 2, 3, 5, 7, 0, ALU_CTRL_ADD, C_RTYPE);
    flush = 1;
    tick(); idle();
    check_all();
    chk("flush_rw", ex_reg_write, 0);
    chk("flush_mw", ex_mem_write, 0);

    // hold with flush keeps the EX contents
    instr(1, 2, 3, 5, 7, 0, ALU_CTRL_SUB, C_RTYPE);
    tick();
    instr(8, 9, 10, 32'h99, 32'h98, 0, ALU_CTRL_OR, C_RTYPE);
    hold = 1; flush = 1;
    tick();
    check_all();
    chk("hold_valid", ex_valid, 1);
    chk("hold_op1", alu_op1, 5);
    chk("hold_ctrl", alu_control, ALU_CTRL_SUB);
    idle(); tick();

    // hold masks a load-use pattern
    instr(1, 4, 0, 32'h100, 32'h0, 0, ALU_CTRL_ADD, C_LW);
    tick();
    instr(4, 1, 5, 32'h0, 32'h100, 0, ALU_CTRL_ADD, C_RTYPE);
    hold = 1;
    check_all();
    chk("hold_no_stall", load_use_stall, 0);
    idle(); tick();

    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alu_control = 4'($urandom);
      {id_uses_rt, id_alu_src, id_reg_dst, id_reg_write,
       id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 8'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7));
      exmem_res = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 7));
      memwb_wdata = $urandom;
      check_all();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_id_ex_stage.md
Name: pl_id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS core, with EX-stage operand forwarding and load-use hazard detection.
- Captures decoded operands and control from ID each cycle.
- Resolves forwarding from EX/MEM and MEM/WB, then drives op1/op2/alu_control straight into the ALU.
- Flags load-use hazards so IF/ID holds and a bubble enters EX.

Parameters:
DATA_W, 32, datapath width
RADDR_W, 5, register-file address width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous assert, active-low
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  RADDR_W  register addresses
id_uses_rt  in  1  instruction reads rt as a source (R-type, beq/bne, sw)
id_alu_control  in  4  ALU_CTRL_* code
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control
flush  in  1  branch redirect; kill the instruction entering EX
hold  in  1  downstream freeze; ID/EX keeps its contents
exmem_reg_write  in  1  forwarding source 1
exmem_rd  in  RADDR_W
exmem_res  in  DATA_W
memwb_reg_write  in  1  forwarding source 2
memwb_rd  in  RADDR_W
memwb_wdata  in  DATA_W
alu_op1, alu_op2  out  DATA_W  ALU operands
alu_control  out  4  registered ALU code
ex_store_data  out  DATA_W  forwarded rt value for sw
ex_write_reg  out  RADDR_W  destination register
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
load_use_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n=0, asynchronous): all registered fields are 0, giving a bubble.
  - ex_valid=0, all control bits 0, alu_control=4'b0000, data/address fields 0.
  - Outputs remain combinationally consistent with these zeros.
- Register update on the rising edge, highest priority first:
  - hold=1: keep all contents. flush and load_use are ignored; the upstream source keeps flush asserted until hold drops.
  - flush=1 or load_use_stall=1: load a bubble (valid and all control bits 0, data fields don't-care but driven 0).
  - Otherwise: capture all id_* fields. Control bits are gated by id_valid.
- Latency: ID inputs appear at the EX outputs one cycle later.
- Forwarding (combinational, per source operand, implemented in pl_forward_unit):
  - Priority 1, EX/MEM: use exmem_res if exmem_reg_write and exmem_rd == src and src != 0.
  - Priority 2, MEM/WB: else use memwb_wdata if memwb_reg_write and memwb_rd == src and src != 0.
  - Otherwise use the registered value.
  - Register 0 is never forwarded and always reads 0 from the register file.
  - When EX/MEM and MEM/WB match the same register, EX/MEM wins.
- Operand and destination selection:
  - alu_op1 = fwd_rs.
  - alu_op2 = ex_alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt, regardless of alu_src.
  - ex_write_reg = reg_dst ? rd : rt.
- load_use_stall (combinational) asserts when all of the following hold:
  - ex_valid and ex_mem_read are set, and registered rt != 0;
  - and either registered rt == id_rs, or (id_uses_rt and registered rt == id_rt).
  - It is further gated by id_valid and by !hold.
  - The cycle after a stall, the bubble sits in EX and the load is in MEM, so MEM/WB forwarding resolves the dependence.
- Overflow and zero come from the ALU. This block consumes neither.

Decomposition:
- Add to the shared defines/package (alongside the ALU_CTRL_* codes):
  - idex_ctrl_t packed struct: valid, reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, reg_dst, alu_control.
  - FWD_REG, FWD_EXMEM and FWD_MEMWB selector constants.
- Sub-module pl_forward_unit: purely combinational. Inputs are src address, the two write-back tags, and the three candidate values; outputs are the selected value and the selector.
- Instantiate pl_forward_unit twice, once for rs and once for rt.

Test Plan:
- Reset: assert rst_n=0 mid-operation with ex_valid=1. Required: ex_valid=0 and all controls 0 immediately, before any clock edge; alu_op1=0.
- add r3,r1,r2 (r1=5, r2=7), no hazards. Required: one cycle later alu_op1=5, alu_op2=7, alu_control=ALU_CTRL_ADD, ex_write_reg=3.
- Back-to-back forwarding:
  - exmem (rd=3, res=0x10) and memwb (rd=3, wdata=0x20) both match src rs=3. Required: alu_op1=0x10.
  - With exmem_reg_write=0 instead. Required: alu_op1=0x20.
  - With rd=0 on both sources. Required: alu_op1 takes the registered value.
- Load-use: lw r4 in EX, then add r5,r4,r1 in ID. Required: load_use_stall=1 for exactly one cycle and the next EX is a bubble. The add then enters EX with a MEM/WB forward of the load data (0xCAFE) giving alu_op1=0xCAFE.
- sw r6,8(r2) with r6 forwarded from EX/MEM (0xDEAD), alu_src=1, imm=8. Required: alu_op2=8 and ex_store_data=0xDEAD.
- Flush and hold:
  - flush=1. Required: EX becomes a bubble next cycle (ex_reg_write=0, ex_mem_write=0).
  - hold=1 together with flush=1. Required: contents unchanged.
  - hold=1 with a load-use pattern present. Required: load_use_stall=0.
